// File: rtl/fifo_drain_serializer.sv
// Drains a show-ahead FIFO one word at a time and shifts each word out as a framed serial line:
// start bit, data LSB-first, optional even parity, stop bit, then a short guard gap.
module fifo_drain_serializer #(
  parameter int bits         = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int GUARD_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifoEmpty,
  input  logic [bits-1:0] fifoData,
  input  logic            txEnable,
  output logic            rdEnable,
  output logic            serOut,
  output logic            busy,
  output logic            frameDone
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (bits > 1) ? $clog2(bits) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST    = IW'(bits - 1);
  localparam logic [GW-1:0] GUARD_LAST  = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GUARD
  } stateT;

  stateT           state;
  logic [bits-1:0] shiftReg;
  logic            parityBit;
  logic [CW-1:0]   bitCnt;
  logic [IW-1:0]   bitIdx;
  logic [GW-1:0]   guardCnt;

  logic canStart;
  logic startNow;
  logic bitEnd;

  assign canStart = !fifoEmpty && txEnable;
  assign bitEnd   = (bitCnt == BIT_LAST);
  // The edge that closes the guard gap doubles as the next sampling edge.
  assign startNow = canStart &&
                    ((state == IDLE) || ((state == GUARD) && (guardCnt == GUARD_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      serOut    <= 1'b1;
      rdEnable  <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      bitCnt    <= '0;
      bitIdx    <= '0;
      guardCnt  <= '0;
    end else begin
      rdEnable  <= 1'b0;
      frameDone <= 1'b0;
      if (startNow) begin
        shiftReg  <= fifoData;
        parityBit <= ^fifoData;
        rdEnable  <= 1'b1;
        serOut    <= 1'b0;
        busy      <= 1'b1;
        bitCnt    <= '0;
        bitIdx    <= '0;
        guardCnt  <= '0;
        state     <= START;
      end else begin
        case (state)
          IDLE: begin
            serOut <= 1'b1;
            busy   <= 1'b0;
          end
          START: begin
            if (bitEnd) begin
              bitCnt   <= '0;
              serOut   <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              state    <= DATA;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          DATA: begin
            if (bitEnd) begin
              bitCnt <= '0;
              if (bitIdx == IDX_LAST) begin
                if (PARITY_EN != 0) begin
                  serOut <= parityBit;
                  state  <= PARITY;
                end else begin
                  serOut <= 1'b1;
                  state  <= STOP;
                end
              end else begin
                bitIdx   <= bitIdx + 1'b1;
                serOut   <= shiftReg[0];
                shiftReg <= shiftReg >> 1;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          PARITY: begin
            if (bitEnd) begin
              bitCnt <= '0;
              serOut <= 1'b1;
              state  <= STOP;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          STOP: begin
            if (bitEnd) begin
              bitCnt   <= '0;
              guardCnt <= '0;
              state    <= GUARD;
            end else begin
              bitCnt <= bitCnt + 1'b1;
              // Registered pulse must be set one cycle early to land on the last stop cycle.
              if (bitCnt == BIT_PRELAST) frameDone <= 1'b1;
            end
          end
          GUARD: begin
            serOut <= 1'b1;
            if (guardCnt == GUARD_LAST) begin
              guardCnt <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              guardCnt <= guardCnt + 1'b1;
            end
          end
          default: begin
            serOut <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: two instances (no parity / even parity) share one emulated FIFO
// and are checked every cycle against a frame-level reference model.
module tb_fifo_drain_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifoEmpty;
  logic [7:0] fifoData;
  logic       txEn0, txEn1;
  logic       rd0, ser0, busy0, fd0;
  logic       rd1, ser1, busy1, fd1;

  always #5 clk = ~clk;

  fifo_drain_serializer #(.bits(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .GUARD_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .fifoEmpty(fifoEmpty), .fifoData(fifoData), .txEnable(txEn0),
    .rdEnable(rd0), .serOut(ser0), .busy(busy0), .frameDone(fd0));

  fifo_drain_serializer #(.bits(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .GUARD_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .fifoEmpty(fifoEmpty), .fifoData(fifoData), .txEnable(txEn1),
    .rdEnable(rd1), .serOut(ser1), .busy(busy1), .frameDone(fd1));

  typedef struct packed {logic ser; logic rd; logic fd;} slotT;
  typedef slotT slotQ[$];
  localparam slotT IDLE_SLOT = '{ser: 1'b1, rd: 1'b0, fd: 1'b0};

  slotQ exp0, exp1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fifoQ[$];
  int   lagSet = 0, lagLeft = 0;
  int   pops0 = 0, pops1 = 0, lastPop0 = -1, lastPop1 = -1, popGap0 = 0;
  int   fdCyc0 = 0, fdCyc1 = 0;

  // Expected line, pop strobe and done pulse for one whole frame plus guard gap.
  function automatic slotQ buildFrame(logic [7:0] w, bit par);
    slotQ q;
    logic lb[$];
    slotT s;
    int   f;
    lb.push_back(1'b0);
    for (int i = 0; i < 8; i++) lb.push_back(w[i]);
    if (par) lb.push_back(^w);
    lb.push_back(1'b1);
    f = lb.size() * 4;
    for (int c = 0; c < f + 3; c++) begin
      s.ser = (c < f) ? lb[c / 4] : 1'b1;
      s.rd  = (c == 0);
      s.fd  = (c == f - 1);
      q.push_back(s);
    end
    return q;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    if (fifoQ.size() > 0) begin
      fifoData  = 8'(fifoQ[0]);
      fifoEmpty = 1'b0;
    end else begin
      fifoData = 8'($urandom);
      if (lagLeft > 0) lagLeft--;
      else fifoEmpty = 1'b1;
    end
  endtask

  task automatic step();
    slotT e0, e1;
    logic b0, b1;
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (exp0.size() == 0 && !fifoEmpty && txEn0) exp0 = buildFrame(fifoData, 1'b0);
      if (exp1.size() == 0 && !fifoEmpty && txEn1) exp1 = buildFrame(fifoData, 1'b1);
    end
    b0 = (exp0.size() != 0);
    b1 = (exp1.size() != 0);
    if (b0) e0 = exp0.pop_front(); else e0 = IDLE_SLOT;
    if (b1) e1 = exp1.pop_front(); else e1 = IDLE_SLOT;
    @(posedge clk);
    #1;
    cyc++;
    chk("ser0", ser0, e0.ser);
    chk("rd0", rd0, e0.rd);
    chk("busy0", busy0, b0);
    chk("done0", fd0, e0.fd);
    chk("ser1", ser1, e1.ser);
    chk("rd1", rd1, e1.rd);
    chk("busy1", busy1, b1);
    chk("done1", fd1, e1.fd);
    if (rd0) begin
      pops0++;
      if (lastPop0 >= 0) popGap0 = cyc - lastPop0;
      lastPop0 = cyc;
    end
    if (rd1) begin
      pops1++;
      lastPop1 = cyc;
    end
    if (fd0) fdCyc0 = cyc;
    if (fd1) fdCyc1 = cyc;
    if ((rd0 || rd1) && fifoQ.size() > 0) begin
      void'(fifoQ.pop_front());
      lagLeft = lagSet;
    end
    refresh();
  endtask

  task automatic waitIdle(int maxCyc);
    int n = 0;
    while ((exp0.size() + exp1.size() + fifoQ.size()) != 0 && n < maxCyc) begin
      step();
      n++;
    end
    chk("drainTimeout", (exp0.size() + exp1.size() + fifoQ.size()) == 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    txEn0 = 1'b0;
    txEn1 = 1'b0;
    fifoEmpty = 1'b1;
    fifoData = 8'h00;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // Asynchronous reset in the middle of DATA (word 00 keeps the line low there)
    fifoQ.push_back(8'h00);
    txEn0 = 1'b1;
    refresh();
    repeat (12) step();
    chk("preRstSer", ser0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rstSer", ser0, 1);
    chk("rstBusy", busy0, 0);
    chk("rstRd", rd0, 0);
    txEn0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    refresh();
    repeat (10) step();

    // Single word A5, no parity
    pops0 = 0;
    lastPop0 = -1;
    fifoQ.push_back(8'hA5);
    txEn0 = 1'b1;
    refresh();
    waitIdle(200);
    repeat (5) step();
    chk("a5Pops", pops0, 1);
    chk("a5DoneAt", fdCyc0 - lastPop0, 39);

    // Parity instance, word 07
    txEn0 = 1'b0;
    txEn1 = 1'b1;
    pops1 = 0;
    fifoQ.push_back(8'h07);
    refresh();
    waitIdle(200);
    repeat (5) step();
    chk("parPops", pops1, 1);
    chk("parDoneAt", fdCyc1 - lastPop1, 43);

    // Back-to-back with a lagging empty flag
    txEn1 = 1'b0;
    txEn0 = 1'b1;
    lagSet = 2;
    pops0 = 0;
    lastPop0 = -1;
    fifoQ.push_back(8'h01);
    fifoQ.push_back(8'h80);
    refresh();
    waitIdle(300);
    repeat (10) step();
    chk("b2bPops", pops0, 2);
    chk("b2bGap", popGap0, 43);

    // txEnable gating
    lagSet = 0;
    txEn0 = 1'b0;
    pops0 = 0;
    fifoQ.push_back(8'h5A);
    refresh();
    repeat (10) step();
    chk("gatedPops", pops0, 0);
    txEn0 = 1'b1;
    step();
    chk("enPops", pops0, 1);
    repeat (10) step();
    txEn0 = 1'b0;
    waitIdle(200);
    repeat (3) step();
    chk("enDoneAt", fdCyc0 - lastPop0, 39);

    // FIFO head moves to FF while 3C is still being shifted
    txEn0 = 1'b1;
    lagSet = 1;
    fifoQ.push_back(8'h3C);
    fifoQ.push_back(8'hFF);
    refresh();
    waitIdle(300);
    repeat (5) step();

    // Randomized traffic, one instance enabled at a time
    for (int r = 0; r < 6; r++) begin
      int n;
      int k = 0;
      lagSet = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) fifoQ.push_back(int'($urandom_range(0, 255)));
      refresh();
      while ((exp0.size() + exp1.size() + fifoQ.size()) != 0 && k < 600) begin
        if (r % 2 == 0) begin
          txEn0 = ($urandom_range(0, 3) != 0);
          txEn1 = 1'b0;
        end else begin
          txEn1 = ($urandom_range(0, 3) != 0);
          txEn0 = 1'b0;
        end
        step();
        k++;
      end
      chk("randTimeout", (exp0.size() + exp1.size() + fifoQ.size()) == 0, 1);
      txEn0 = 1'b0;
      txEn1 = 1'b0;
      repeat ($urandom_range(1, 6)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
